// File: rtl/turn_signal_pkg.sv
// Shared types and helpers for the turn-signal sequencer.
package turn_signal_pkg;

   typedef enum logic [1:0] {
      M_IDLE   = 2'd0,
      M_LEFT   = 2'd1,
      M_RIGHT  = 2'd2,
      M_HAZARD = 2'd3
   } mode_t;

   localparam int MAX_LAMPS = 16;

   // Thermometer mask: the lowest 'step' bits set, inner lamp at bit 0.
   function automatic logic [MAX_LAMPS-1:0] thermo(input logic [4:0] step);
      logic [MAX_LAMPS-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_LAMPS; i++) begin
         m[i] = (i < int'(step));
      end
      return m;
   endfunction

endpackage

// File: rtl/turn_signal_seq_tick_gen.sv
// Free-running prescaler; tick is high on the last count of each DIV-cycle window.
module tick_gen #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] cnt_q;
   logic [PW-1:0] cnt_d;

   assign tick  = (cnt_q == LAST);
   assign cnt_d = tick ? '0 : cnt_q + PW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/turn_signal_seq.sv
// Tail-light sequencer: left/right thermometer sweep and hazard flash,
// stepping once per prescaler tick; new requests are taken only at the all-off step.
module turn_signal_seq
   import turn_signal_pkg::*;
#(
   parameter int N_LAMPS  = 3,
   parameter int TICK_DIV = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               left,
   input  logic               right,
   input  logic               hazard,
   output logic [N_LAMPS-1:0] lamps_l,
   output logic [N_LAMPS-1:0] lamps_r,
   output logic [1:0]         mode,
   output logic               busy
);

   localparam int SW = $clog2(N_LAMPS + 1);
   localparam logic [SW-1:0] LAST_STEP = SW'(N_LAMPS);

   logic               tick;
   mode_t              req;
   mode_t              mode_q, mode_d;
   logic [SW-1:0]      step_q, step_d;
   logic [N_LAMPS-1:0] lamps_l_q, lamps_l_d;
   logic [N_LAMPS-1:0] lamps_r_q, lamps_r_d;
   logic               busy_q;

   tick_gen #(.DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   always_comb begin
      req = M_IDLE;
      if (hazard | (left & right)) req = M_HAZARD;
      else if (left)               req = M_LEFT;
      else if (right)              req = M_RIGHT;
   end

   always_comb begin
      mode_d = mode_q;
      step_d = step_q;
      if (tick) begin
         if (int'(step_q) > N_LAMPS) begin
            mode_d = M_IDLE;
            step_d = '0;
         end else if (mode_q == M_IDLE || step_q == '0) begin
            // Sequence boundary: the only point where the request is looked at.
            mode_d = req;
            step_d = (req == M_IDLE) ? '0 : SW'(1);
         end else if (mode_q == M_HAZARD || step_q == LAST_STEP) begin
            step_d = '0;
         end else begin
            step_d = step_q + SW'(1);
         end
      end

      lamps_l_d = '0;
      lamps_r_d = '0;
      case (mode_d)
         M_LEFT:   lamps_l_d = N_LAMPS'(thermo(5'(step_d)));
         M_RIGHT:  lamps_r_d = N_LAMPS'(thermo(5'(step_d)));
         M_HAZARD: begin
            lamps_l_d = (step_d != '0) ? '1 : '0;
            lamps_r_d = (step_d != '0) ? '1 : '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q    <= M_IDLE;
         step_q    <= '0;
         lamps_l_q <= '0;
         lamps_r_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         step_q    <= step_d;
         lamps_l_q <= lamps_l_d;
         lamps_r_q <= lamps_r_d;
         busy_q    <= (mode_d != M_IDLE);
      end
   end

   assign lamps_l = lamps_l_q;
   assign lamps_r = lamps_r_q;
   assign mode    = mode_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_turn_signal_seq.sv
// Bench for turn_signal_seq: three parameterisations driven in parallel, directed
// scenarios with fixed expectations plus randomized requests against a reference model.
module tb_turn_signal_seq;

   logic clk = 1'b0;
   logic reset, left, right, hazard;

   logic [2:0] a_l, a_r;
   logic [3:0] b_l, b_r;
   logic [4:0] c_l, c_r;
   logic [1:0] a_mode, b_mode, c_mode;
   logic       a_busy, b_busy, c_busy;

   always #5 clk = ~clk;

   turn_signal_seq #(.N_LAMPS(3), .TICK_DIV(1)) dut_a (
      .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
      .lamps_l(a_l), .lamps_r(a_r), .mode(a_mode), .busy(a_busy));
   turn_signal_seq #(.N_LAMPS(4), .TICK_DIV(4)) dut_b (
      .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
      .lamps_l(b_l), .lamps_r(b_r), .mode(b_mode), .busy(b_busy));
   turn_signal_seq #(.N_LAMPS(5), .TICK_DIV(1)) dut_c (
      .clk(clk), .reset(reset), .left(left), .right(right), .hazard(hazard),
      .lamps_l(c_l), .lamps_r(c_r), .mode(c_mode), .busy(c_busy));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: mode 0..3 = idle/left/right/hazard, pos = position in the pattern.
   localparam int NI = 3;
   int NL[NI] = '{3, 4, 5};
   int DV[NI] = '{1, 4, 1};
   int m_mode[NI];
   int m_pos[NI];
   int m_cnt[NI];
   int r_req;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NI; k++) begin
            m_mode[k] = 0; m_pos[k] = 0; m_cnt[k] = 0;
         end
      end else begin
         r_req = (hazard || (left && right)) ? 3 : left ? 1 : right ? 2 : 0;
         for (int k = 0; k < NI; k++) begin
            if (m_cnt[k] == DV[k] - 1) begin
               m_cnt[k] = 0;
               if (m_mode[k] == 0 || m_pos[k] == 0) begin
                  m_mode[k] = r_req;
                  m_pos[k]  = (r_req == 0) ? 0 : 1;
               end else begin
                  m_pos[k] = (m_pos[k] + 1) % ((m_mode[k] == 3) ? 2 : NL[k] + 1);
               end
            end else begin
               m_cnt[k] = m_cnt[k] + 1;
            end
         end
      end
   end

   function automatic logic [31:0] exp_side(int k, int side);
      if (m_mode[k] == side) return (32'd1 << m_pos[k]) - 1;
      if (m_mode[k] == 3 && m_pos[k] == 1) return (32'd1 << NL[k]) - 1;
      return 32'd0;
   endfunction

   function automatic logic [31:0] got_l(int k);
      return (k == 0) ? 32'(a_l) : (k == 1) ? 32'(b_l) : 32'(c_l);
   endfunction
   function automatic logic [31:0] got_r(int k);
      return (k == 0) ? 32'(a_r) : (k == 1) ? 32'(b_r) : 32'(c_r);
   endfunction
   function automatic logic [31:0] got_m(int k);
      return (k == 0) ? 32'(a_mode) : (k == 1) ? 32'(b_mode) : 32'(c_mode);
   endfunction
   function automatic logic [31:0] got_b(int k);
      return (k == 0) ? 32'(a_busy) : (k == 1) ? 32'(b_busy) : 32'(c_busy);
   endfunction

   task automatic check_all(input string ph);
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("%s.lamps_l[%0d]", ph, k), got_l(k), exp_side(k, 1));
         chk($sformatf("%s.lamps_r[%0d]", ph, k), got_r(k), exp_side(k, 2));
         chk($sformatf("%s.mode[%0d]", ph, k), got_m(k), 32'(m_mode[k]));
         chk($sformatf("%s.busy[%0d]", ph, k), got_b(k), 32'(m_mode[k] != 0));
      end
   endtask

   task automatic check_zero(input string ph);
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("%s.lamps_l[%0d]", ph, k), got_l(k), 32'd0);
         chk($sformatf("%s.lamps_r[%0d]", ph, k), got_r(k), 32'd0);
         chk($sformatf("%s.mode[%0d]", ph, k), got_m(k), 32'd0);
         chk($sformatf("%s.busy[%0d]", ph, k), got_b(k), 32'd0);
      end
   endtask

   // Asynchronous reset pulse between clock edges, checked before the next edge.
   task automatic async_reset(input string ph);
      reset = 1'b1;
      #1;
      check_zero(ph);
      #1;
   endtask

   int presc_tbl[6] = '{0, 1, 3, 7, 15, 0};
   int sw_l[9]      = '{1, 3, 7, 0, 1, 3, 7, 0, 0};
   int sw_m[9]      = '{1, 1, 1, 1, 1, 1, 1, 1, 2};
   int drop_l[8]    = '{1, 3, 7, 15, 31, 0, 0, 0};
   int drop_m[8]    = '{1, 1, 1, 1, 1, 1, 0, 0};

   initial begin
      reset = 1'b0; left = 1'b0; right = 1'b0; hazard = 1'b0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      check_zero("reset");

      // Prescaler: right held, N=4 DIV=4 steps every 4 clocks.
      right = 1'b1; reset = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         chk($sformatf("presc.c%0d", c), 32'(b_r), 32'(presc_tbl[c / 4]));
         check_all("presc");
      end
      @(negedge clk);
      check_all("presc_end");
      right = 1'b0;
      async_reset("midsweep_reset");

      // Left sweep on N=3, then right requested mid-sweep.
      left = 1'b1; reset = 1'b0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         chk($sformatf("sweep.l.c%0d", c), 32'(a_l), 32'(sw_l[c - 1]));
         chk($sformatf("sweep.r.c%0d", c), 32'(a_r), (c == 9) ? 32'd1 : 32'd0);
         chk($sformatf("sweep.mode.c%0d", c), 32'(a_mode), 32'(sw_m[c - 1]));
         check_all("sweep");
         if (c == 6) begin
            left = 1'b0; right = 1'b1;
         end
      end
      right = 1'b0;
      async_reset("reset2");

      // Hazard via left and right together.
      left = 1'b1; right = 1'b1; reset = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         chk($sformatf("haz.l.c%0d", c), 32'(a_l), (c % 2 == 1) ? 32'd7 : 32'd0);
         chk($sformatf("haz.r.c%0d", c), 32'(a_r), (c % 2 == 1) ? 32'd7 : 32'd0);
         chk($sformatf("haz.mode.c%0d", c), 32'(a_mode), 32'd3);
         check_all("haz");
      end
      left = 1'b0; right = 1'b0;
      async_reset("reset3");

      // Left dropped at step 2 on N=5: sweep finishes, then idle.
      left = 1'b1; reset = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk($sformatf("drop.l.c%0d", c), 32'(c_l), 32'(drop_l[c - 1]));
         chk($sformatf("drop.mode.c%0d", c), 32'(c_mode), 32'(drop_m[c - 1]));
         chk($sformatf("drop.busy.c%0d", c), 32'(c_busy), 32'(drop_m[c - 1] != 0));
         check_all("drop");
         if (c == 2) left = 1'b0;
      end

      // Randomized requests with occasional asynchronous resets.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         check_all("rand");
         if ($urandom_range(0, 99) < 15) begin
            left   = 1'($urandom_range(0, 1));
            right  = 1'($urandom_range(0, 1));
            hazard = ($urandom_range(0, 5) == 0);
         end
         if ($urandom_range(0, 299) == 0) begin
            async_reset("rand_reset");
            reset = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/turn_signal_seq.md
Name: turn_signal_seq

Overview:
- Parametrised successor to the 3-lamp left/right tail-light FSM.
- Drives N_LAMPS lamps per side with a progressive "sweep" pattern, left or right.
- Adds a hazard mode (both sides flash together), taken when `hazard` is asserted or when `left` and `right` are both high.
- Adds a programmable step prescaler so lamp rate is decoupled from clk.
- Sits between driver-input logic and the lamp outputs.

Parameters:
- N_LAMPS, 3: lamps per side; legal range 1..16.
- TICK_DIV, 1: clk cycles per sequence step; legal range ≥1; 1 means step every cycle.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- left  input  1  left turn request, level-sensitive.
- right  input  1  right turn request, level-sensitive.
- hazard  input  1  hazard request, level-sensitive.
- lamps_l  output  N_LAMPS  left lamps; bit 0 = innermost (LA).
- lamps_r  output  N_LAMPS  right lamps; bit 0 = innermost (RA).
- mode  output  2  current mode_t (IDLE/LEFT/RIGHT/HAZARD).
- busy  output  1  high when mode != IDLE.

Behaviour:
- Clock and reset are fixed: one clock, `clk`; `reset` is asynchronous and active-high.
- Reset (async, any time, including mid-sequence):
  - mode=IDLE, step=0, prescaler=0.
  - lamps_l=lamps_r=0, busy=0.
  - All outputs are registered.
- Tick generation:
  - prescaler counts 0..TICK_DIV-1 and wraps; free-running from reset release.
  - tick=1 in cycles where prescaler==TICK_DIV-1.
  - TICK_DIV=1 gives tick=1 in every cycle.
  - All state changes occur only on clk edges with tick=1.
- Request decode (combinational, sampled on tick):
  - hazard | (left & right) → HAZARD.
  - else left → LEFT.
  - else right → RIGHT.
  - else IDLE.
- Mode changes are accepted only at a sequence boundary:
  - IDLE, or
  - step==0 (the all-off step) of any mode.
  - Requests that change or drop mid-sweep are ignored until the sweep completes.
- LEFT/RIGHT sweep:
  - step counter 0..N_LAMPS, width $clog2(N_LAMPS+1).
  - At a boundary with the request present: step←1, active side lamps = {{N-1{0}},1}.
  - Each subsequent tick: step+1, lamps = (1<<step)-1 (thermometer, inner to outer).
  - After step==N_LAMPS (all lit), next tick: step←0, lamps←0.
  - Period is N_LAMPS+1 ticks. Inactive side stays 0.
- HAZARD:
  - step alternates 1 (both sides all-ones) and 0 (both sides all-zero); period 2 ticks.
  - Request re-evaluated on the all-off step only.
- Latency: from IDLE, a request present at a tick edge shows on lamps at that same edge (registered).
- Boundary rules:
  - Request at a boundary with no tick: held off until the next tick; not latched.
  - Request pulse shorter than the gap between ticks may be missed; this is accepted.
  - At a boundary with no request: return to IDLE, lamps 0.
  - Sweep uses only step values 0..N_LAMPS; no illegal step reachable. Any out-of-range step → step 0, mode IDLE on next tick.
- mode and busy change on the same edge as the mode register.

Decomposition:
- Package `turn_signal_pkg`:
  - typedef enum logic [1:0] mode_t {M_IDLE=0, M_LEFT=1, M_RIGHT=2, M_HAZARD=3}.
  - Function thermo(step) returning the N-bit lamp mask.
- Sub-module `tick_gen`:
  - Parameter DIV; ports clk, reset, tick.
  - Prescaler width $clog2(DIV), minimum 1.
- Top: mode FSM + step counter + output registers.

Test Plan:
- Reset: reset=1 mid-sweep at N=3 → lamps_l=lamps_r=000, mode=IDLE, busy=0 immediately (async), before the next clk edge.
- Left sweep, N=3, TICK_DIV=1, left held:
  - lamps_l sequence across consecutive edges = 001, 011, 111, 000, 001…
  - lamps_r=000 throughout; mode=LEFT while sweeping.
- Mid-sweep change, N=3:
  - right asserted and left dropped when lamps_l=011 → lamps_l completes 111, 000.
  - Then lamps_r=001 on the following edge.
- Hazard by both inputs, N=3: left=right=1 from IDLE → lamps_l=lamps_r alternate 111/000 every edge; mode=HAZARD.
- Prescaler, N=4, TICK_DIV=4, right held:
  - lamps_r changes exactly every 4 clks: 0001, 0011, 0111, 1111, 0000.
  - No change in intervening cycles.
- Drop request: left released during step 2 of N=5 → sweep completes to 11111, then 00000, then mode=IDLE, busy=0, lamps stay 0.
